// File: rtl/cmult_pkg.sv
// rtl/cmult_pkg.sv - shared constants and helpers for the cmult_pipe complex multiplier
package cmult_pkg;

  // Register stages from operand capture to the visible result.
  localparam int CMULT_LATENCY = 3;

  // Half an output LSB of a Q1.(tw_width-1) scaled product, added before the shift for round-half-up.
  function automatic longint unsigned cmult_rnd_const(input int tw_width);
    return 64'd1 << (tw_width - 2);
  endfunction

endpackage

// File: rtl/cmult_scale.sv
// rtl/cmult_scale.sv - rescales one full product back to data scale, optionally rounding
module cmult_scale
  import cmult_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
) (
  input  logic signed [WIDTH+TW_WIDTH-1:0] prod,
  input  logic                             rnd,
  output logic signed [WIDTH:0]            scaled
);

  localparam int PW = WIDTH + TW_WIDTH;
  localparam logic [PW-1:0] RND_C = PW'(cmult_rnd_const(TW_WIDTH));

  logic signed [PW-1:0] biased;

  // The full product cannot reach the top of its range, so the bias never overflows PW bits.
  always_comb begin
    biased = prod;
    if (rnd) begin
      biased = prod + RND_C;
    end
    scaled = (WIDTH+1)'(biased >>> (TW_WIDTH - 1));
  end

endmodule

// File: rtl/cmult_pipe.sv
// rtl/cmult_pipe.sv - 3-stage pipelined complex multiplier with global stall; CMULT_SAT_EN enables saturation and sticky ovf
module cmult_pipe
  import cmult_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [WIDTH-1:0]    ar,
  input  logic signed [WIDTH-1:0]    ai,
  input  logic signed [TW_WIDTH-1:0] br,
  input  logic signed [TW_WIDTH-1:0] bi,
  input  logic                       conj,
  input  logic                       rnd,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH-1:0]    mr,
  output logic signed [WIDTH-1:0]    mi,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int PW = WIDTH + TW_WIDTH;

  logic                       advance;
  logic                       s1_valid_q, s1_valid_d;
  logic                       s2_valid_q, s2_valid_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0]    ar_q, ar_d, ai_q, ai_d;
  logic signed [TW_WIDTH-1:0] br_q, br_d, bi_q, bi_d;
  logic                       conj1_q, conj1_d, rnd1_q, rnd1_d;
  logic signed [PW-1:0]       p_rr_q, p_rr_d, p_ri_q, p_ri_d;
  logic signed [PW-1:0]       p_ir_q, p_ir_d, p_ii_q, p_ii_d;
  logic                       conj2_q, conj2_d, rnd2_q, rnd2_d;
  logic signed [WIDTH:0]      s_rr, s_ri, s_ir, s_ii;
  logic signed [WIDTH:0]      re_sum, im_sum;
  logic signed [WIDTH-1:0]    re_lim, im_lim;
  logic signed [WIDTH-1:0]    mr_q, mr_d, mi_q, mi_d;

  // One global advance: the whole pipe moves only when the output slot is free or being taken.
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign mr        = mr_q;
  assign mi        = mi_q;

  // Valid bits step one stage per advance; bubbles travel as zeros and are never squeezed out.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    out_valid_d = out_valid_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
    end
  end

  // Valid bits and the result registers are reset so a reset flushes every in-flight sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mr_q        <= '0;
      mi_q        <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      mr_q        <= mr_d;
      mi_q        <= mi_d;
    end
  end

  // S1 captures operands and mode bits; S2 forms the four full-width partial products.
  always_comb begin
    ar_d    = ar_q;
    ai_d    = ai_q;
    br_d    = br_q;
    bi_d    = bi_q;
    conj1_d = conj1_q;
    rnd1_d  = rnd1_q;
    p_rr_d  = p_rr_q;
    p_ri_d  = p_ri_q;
    p_ir_d  = p_ir_q;
    p_ii_d  = p_ii_q;
    conj2_d = conj2_q;
    rnd2_d  = rnd2_q;
    if (advance) begin
      ar_d    = ar;
      ai_d    = ai;
      br_d    = br;
      bi_d    = bi;
      conj1_d = conj;
      rnd1_d  = rnd;
      p_rr_d  = PW'(ar_q) * PW'(br_q);
      p_ri_d  = PW'(ar_q) * PW'(bi_q);
      p_ir_d  = PW'(ai_q) * PW'(br_q);
      p_ii_d  = PW'(ai_q) * PW'(bi_q);
      conj2_d = conj1_q;
      rnd2_d  = rnd1_q;
    end
  end

  // S1/S2 data carry no reset; their contents only matter while the matching valid bit is set.
  always_ff @(posedge clk) begin
    ar_q    <= ar_d;
    ai_q    <= ai_d;
    br_q    <= br_d;
    bi_q    <= bi_d;
    conj1_q <= conj1_d;
    rnd1_q  <= rnd1_d;
    p_rr_q  <= p_rr_d;
    p_ri_q  <= p_ri_d;
    p_ir_q  <= p_ir_d;
    p_ii_q  <= p_ii_d;
    conj2_q <= conj2_d;
    rnd2_q  <= rnd2_d;
  end

  cmult_scale #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_scale_rr (.prod(p_rr_q), .rnd(rnd2_q), .scaled(s_rr));
  cmult_scale #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_scale_ri (.prod(p_ri_q), .rnd(rnd2_q), .scaled(s_ri));
  cmult_scale #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_scale_ir (.prod(p_ir_q), .rnd(rnd2_q), .scaled(s_ir));
  cmult_scale #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_scale_ii (.prod(p_ii_q), .rnd(rnd2_q), .scaled(s_ii));

  // Combine scaled products at WIDTH+1 bits; conj flips the sign of the twiddle's imaginary part.
  always_comb begin
    if (conj2_q) begin
      re_sum = s_rr + s_ii;
      im_sum = s_ir - s_ri;
    end else begin
      re_sum = s_rr - s_ii;
      im_sum = s_ri + s_ir;
    end
  end

`ifdef CMULT_SAT_EN
  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic re_ovr, im_ovr, ovf_set, ovf_q, ovf_d;

  // Out of range when the extra sign bit disagrees with the kept MSB; clamp toward the true sign.
  always_comb begin
    re_ovr = re_sum[WIDTH] ^ re_sum[WIDTH-1];
    im_ovr = im_sum[WIDTH] ^ im_sum[WIDTH-1];
    re_lim = re_sum[WIDTH-1:0];
    im_lim = im_sum[WIDTH-1:0];
    if (re_ovr) begin
      re_lim = re_sum[WIDTH] ? MIN_V : MAX_V;
    end
    if (im_ovr) begin
      im_lim = im_sum[WIDTH] ? MIN_V : MAX_V;
    end
    ovf_set = advance && s2_valid_q && (re_ovr || im_ovr);
    ovf_d   = ovf_set || (ovf_q && !ovf_clr);
  end

  // Sticky overflow flag; a set landing in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_nosat;

  // Plain two's complement wrap: drop the extra sum bit.
  always_comb begin
    re_lim = re_sum[WIDTH-1:0];
    im_lim = im_sum[WIDTH-1:0];
  end

  assign unused_nosat = ^{re_sum[WIDTH], im_sum[WIDTH], ovf_clr};
  assign ovf          = 1'b0;
`endif

  // S3 loads only valid samples, so mr/mi hold their last result across bubbles and stalls.
  always_comb begin
    mr_d = mr_q;
    mi_d = mi_q;
    if (advance && s2_valid_q) begin
      mr_d = re_lim;
      mi_d = im_lim;
    end
  end

endmodule

// File: doc/cmult_pipe.md
CMULT_PIPE -- requirements
Module: cmult_pipe

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the data operand a and of both output components.
REQ-002 Parameter TW_WIDTH, default 16: bit width of the twiddle operand b, signed Q1.(TW_WIDTH-1), range 2..WIDTH+8.
REQ-003 Ports: clock in 1, rising-edge clock; reset in 1, asynchronous active-high.
REQ-004 Ports: ar, ai in WIDTH signed, data operand; br, bi in TW_WIDTH signed, twiddle operand.
REQ-005 Ports: conj in 1, use conjugate of b; rnd in 1, 1 = round-half-up, 0 = truncate. Both are sampled with the operands.
REQ-006 Ports: in_valid in 1; in_ready out 1; out_valid out 1; out_ready in 1 (valid/ready handshake).
REQ-007 Ports: mr, mi out WIDTH signed, product; ovf out 1, sticky overflow flag; ovf_clr in 1, clears ovf.

Function
REQ-008 An input transfer shall occur on a clock edge where in_valid && in_ready; an output transfer shall occur where out_valid && out_ready.
REQ-009 Three register stages: S1 captures the operands, conj and rnd; S2 holds the four full products ar*br, ar*bi, ai*br, ai*bi, each WIDTH+TW_WIDTH bits; S3 holds the scaled, combined, limited result.
REQ-010 Latency shall be exactly 3 cycles from input transfer to out_valid when there is no stall.
REQ-011 Global stall: advance = !out_valid || out_ready; in_ready = advance; all stages, including their valid bits, shall hold while advance is 0.
REQ-012 Bubbles shall propagate as invalid stages and shall not be collapsed.
REQ-013 Scaling: each product shall be arithmetically shifted right by TW_WIDTH-1. If rnd=1, 2^(TW_WIDTH-2) shall be added before the shift.
REQ-014 conj=0: mr = s(arbr) - s(aibi), mi = s(arbi) + s(aibr).
REQ-015 conj=1: mr = s(arbr) + s(aibi), mi = s(aibr) - s(arbi).
REQ-016 Add/sub shall be computed at WIDTH+1 bits, then limited to WIDTH per REQ-021.
REQ-017 mr and mi shall remain stable while out_valid && !out_ready.
REQ-018 ovf shall be set on any S3 load whose result exceeds the WIDTH signed range, real or imaginary, for a valid sample only.
REQ-019 ovf shall be cleared by ovf_clr; if set and clear occur in the same cycle, set shall win.

Reset
REQ-020 While reset is high: all stage valid bits, out_valid, ovf, mr and mi shall be 0. The data registers of S1 and S2 may be left unreset. A reset asserted mid-stream shall discard all in-flight samples, and the first output after release shall come from a post-reset input.

Configuration
REQ-021 With macro CMULT_SAT_EN defined: out-of-range results saturate to +(2^(WIDTH-1)-1) or -2^(WIDTH-1) and ovf operates per REQ-018/019. Without it: results wrap to WIDTH bits (two's complement) and ovf shall be tied to 0.

Structure
REQ-022 Package cmult_pkg shall hold the localparam CMULT_LATENCY=3 and the function computing the rounding constant for a given TW_WIDTH.
REQ-023 Sub-module cmult_scale (one product in, one scaled WIDTH+1 value out, rnd input) shall be instantiated four times in S3.

Verification (WIDTH=16, TW_WIDTH=16)
REQ-024 a=(16384,0), b=(32767,0), conj=0: with rnd=0 -> mr=16383, mi=0; with rnd=1 -> mr=16384, mi=0; out_valid exactly 3 cycles after the input transfer.
REQ-025 a=(0,16384), b=(0,32767), rnd=0: conj=0 -> mr=-16383, mi=0; conj=1 -> mr=16383, mi=0.
REQ-026 a=(32767,32767), b=(32767,32767), conj=0, rnd=0: with CMULT_SAT_EN -> mr=0, mi=32767, ovf=1 until ovf_clr; without -> mi=-4, ovf=0.
REQ-027 Hold out_ready=0 and send 5 back-to-back inputs: exactly 3 are accepted before in_ready drops; outputs stay stable; after out_ready=1 all 3 emerge in order with no loss or duplication.
REQ-028 Assert reset for 1 cycle while 3 samples are in flight: out_valid=0 and ovf=0 immediately; no stale sample appears after release; a new input emerges 3 cycles after its transfer.
